// File: rtl/floor_scheduler_if.sv
// Button/position inputs and scheduler outputs for floor_scheduler.
// The master drives calls and car position; the slave is the scheduler.
interface floor_scheduler_if #(
  parameter int FLOORS = 6
);
  logic [FLOORS-1:0] callReq;
  logic [FLOORS-1:0] currentFloor;
  logic [FLOORS-1:0] nextFloor;
  logic [FLOORS-1:0] pending;
  logic              doorOpen;
  logic [1:0]        sweep;

  modport master (
    output callReq, currentFloor,
    input  nextFloor, pending, doorOpen, sweep
  );

  modport slave (
    input  callReq, currentFloor,
    output nextFloor, pending, doorOpen, sweep
  );
endinterface

// File: rtl/floor_scheduler.sv
// SCAN-policy request scheduler for the elevator car: latches calls, picks the
// next target floor, times the door dwell and clears served requests.
module floor_scheduler #(
  parameter int FLOORS      = 6,
  parameter int DOOR_CYCLES = 4
) (
  input logic              clk,
  input logic              reset,
  floor_scheduler_if.slave bus
);
  localparam int IW = (FLOORS > 1) ? $clog2(FLOORS) : 1;
  localparam int CW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [CW-1:0] DWELL_LOAD = CW'(DOOR_CYCLES - 1);

  localparam logic [1:0] SW_UP   = 2'b10;
  localparam logic [1:0] SW_DN   = 2'b01;
  localparam logic [1:0] SW_NONE = 2'b00;

  typedef enum logic [1:0] {
    IDLE,
    SERVE,
    DOOR
  } state_t;

  state_t            state_q;
  logic [FLOORS-1:0] pending_q;
  logic [FLOORS-1:0] next_q;
  logic              door_q;
  logic [1:0]        sweep_q;
  logic [CW-1:0]     cnt_q;

  logic              cur_valid;
  logic [IW-1:0]     cur_idx;
  logic [IW-1:0]     up_idx;
  logic [IW-1:0]     dn_idx;
  logic              up_found;
  logic              dn_found;
  logic              pick_up;
  logic              has_tgt;
  logic [IW-1:0]     tgt_idx;
  logic [FLOORS-1:0] tgt_d;
  logic [FLOORS-1:0] latched;
  logic              at_call;
  logic              at_target;
  logic              reopen;

  assign cur_valid = $onehot(bus.currentFloor);
  assign latched   = pending_q | bus.callReq;
  assign at_call   = |(pending_q & bus.currentFloor);
  assign at_target = cur_valid && (bus.currentFloor == next_q);
  assign reopen    = |(bus.callReq & bus.currentFloor);

  // Nearest pending floor strictly above / below the car, then SCAN choice.
  always_comb begin
    cur_idx  = '0;
    up_idx   = '0;
    dn_idx   = '0;
    up_found = 1'b0;
    dn_found = 1'b0;
    for (int unsigned i = 0; i < FLOORS; i++) begin
      if (bus.currentFloor[i]) cur_idx = IW'(i);
    end
    for (int unsigned i = 0; i < FLOORS; i++) begin
      if (pending_q[i] && (IW'(i) > cur_idx) && !up_found) begin
        up_found = 1'b1;
        up_idx   = IW'(i);
      end
      if (pending_q[i] && (IW'(i) < cur_idx)) begin
        dn_found = 1'b1;
        dn_idx   = IW'(i);
      end
    end

    case (sweep_q)
      SW_UP:   pick_up = up_found;
      SW_DN:   pick_up = !dn_found;
      default: pick_up = up_found &&
                         (!dn_found || ((up_idx - cur_idx) <= (cur_idx - dn_idx)));
    endcase

    has_tgt = up_found | dn_found;
    tgt_idx = pick_up ? up_idx : dn_idx;
    tgt_d   = '0;
    if (has_tgt) begin
      for (int unsigned i = 0; i < FLOORS; i++) begin
        if (IW'(i) == tgt_idx) tgt_d[i] = 1'b1;
      end
    end
  end

  // Sweep direction only changes on the IDLE -> SERVE decision.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      next_q    <= '0;
      door_q    <= 1'b0;
      sweep_q   <= SW_NONE;
      cnt_q     <= '0;
    end else begin
      pending_q <= latched;
      case (state_q)
        IDLE: begin
          if (!cur_valid) begin
            state_q <= IDLE;
          end else if (at_call) begin
            state_q   <= DOOR;
            door_q    <= 1'b1;
            cnt_q     <= DWELL_LOAD;
            pending_q <= latched & ~bus.currentFloor;
          end else if (|pending_q) begin
            state_q <= SERVE;
            next_q  <= tgt_d;
            sweep_q <= pick_up ? SW_UP : SW_DN;
          end else begin
            sweep_q <= SW_NONE;
          end
        end

        SERVE: begin
          if (at_target) begin
            state_q   <= DOOR;
            next_q    <= '0;
            door_q    <= 1'b1;
            cnt_q     <= DWELL_LOAD;
            pending_q <= latched & ~bus.currentFloor;
          end else if (pending_q == '0) begin
            state_q <= IDLE;
            next_q  <= '0;
          end else if (cur_valid && has_tgt) begin
            next_q <= tgt_d;
          end
        end

        DOOR: begin
          // A call at the open floor is swallowed and restarts the dwell.
          pending_q <= latched & ~bus.currentFloor;
          if (reopen) begin
            cnt_q <= DWELL_LOAD;
          end else if (cnt_q == '0) begin
            state_q <= IDLE;
            door_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.nextFloor = next_q;
  assign bus.pending   = pending_q;
  assign bus.doorOpen  = door_q;
  assign bus.sweep     = sweep_q;
endmodule

// File: tb/tb_floor_scheduler.sv
// Directed scoreboard bench for floor_scheduler: each step drives inputs,
// queues the outputs expected after the next clock edge, then checks them.
module tb_floor_scheduler;
  localparam logic [5:0] F0 = 6'b000000;
  localparam logic [5:0] F1 = 6'b000001;
  localparam logic [5:0] F2 = 6'b000010;
  localparam logic [5:0] F3 = 6'b000100;
  localparam logic [5:0] F4 = 6'b001000;
  localparam logic [5:0] F5 = 6'b010000;
  localparam logic [5:0] F6 = 6'b100000;
  localparam logic [1:0] U  = 2'b10;
  localparam logic [1:0] D  = 2'b01;
  localparam logic [1:0] N  = 2'b00;

  typedef struct packed {
    logic [5:0] nf;
    logic [5:0] pd;
    logic       dr;
    logic [1:0] sw;
  } exp_t;

  logic  clk = 1'b0;
  logic  reset;
  exp_t  sb[$];
  string tagq[$];
  int    checks = 0;
  int    errors = 0;

  floor_scheduler_if #(.FLOORS(6)) bus ();

  floor_scheduler #(.FLOORS(6), .DOOR_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_out();
    exp_t  e;
    string t;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty got 0 entries required 1");
    end else begin
      e = sb.pop_front();
      t = tagq.pop_front();
      checks++;
      assert (bus.nextFloor === e.nf) else begin
        errors++;
        $error("FAIL %s nextFloor got %b required %b", t, bus.nextFloor, e.nf);
      end
      checks++;
      assert (bus.pending === e.pd) else begin
        errors++;
        $error("FAIL %s pending got %b required %b", t, bus.pending, e.pd);
      end
      checks++;
      assert (bus.doorOpen === e.dr) else begin
        errors++;
        $error("FAIL %s doorOpen got %b required %b", t, bus.doorOpen, e.dr);
      end
      checks++;
      assert (bus.sweep === e.sw) else begin
        errors++;
        $error("FAIL %s sweep got %b required %b", t, bus.sweep, e.sw);
      end
    end
  endtask

  // Drive one cycle of inputs, queue what must appear after the edge, check it.
  task automatic go(input logic [5:0] cr, input logic [5:0] cf, input string tag,
                    input logic [5:0] nf, input logic [5:0] pd,
                    input logic dr, input logic [1:0] sw);
    exp_t e;
    bus.callReq      = cr;
    bus.currentFloor = cf;
    e.nf = nf;
    e.pd = pd;
    e.dr = dr;
    e.sw = sw;
    sb.push_back(e);
    tagq.push_back(tag);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    reset            = 1'b1;
    bus.callReq      = F0;
    bus.currentFloor = F1;
    go(F0, F1, "reset0", F0, F0, 1'b0, N);
    go(F0, F1, "reset1", F0, F0, 1'b0, N);
    reset = 1'b0;

    // Floor 1 to top floor, dwell, then sweep returns to none.
    go(F6, F1, "t1_latch",  F0, F6, 1'b0, N);
    go(F0, F1, "t1_target", F6, F6, 1'b0, U);
    go(F0, F3, "t1_travel", F6, F6, 1'b0, U);
    go(F0, F6, "t1_arrive", F0, F0, 1'b1, U);
    for (int i = 0; i < 3; i++) go(F0, F6, "t1_dwell", F0, F0, 1'b1, U);
    go(F0, F6, "t1_close",  F0, F0, 1'b0, U);
    go(F0, F6, "t1_idle",   F0, F0, 1'b0, N);

    // Closer request in the sweep direction retargets mid-SERVE.
    go(F6, F2, "t2_latch",    F0, F6, 1'b0, N);
    go(F0, F2, "t2_target",   F6, F6, 1'b0, U);
    go(F4, F2, "t2_newreq",   F6, 6'b101000, 1'b0, U);
    go(F0, F2, "t2_retarget", F4, 6'b101000, 1'b0, U);
    go(F0, F4, "t2_arrive",   F0, F6, 1'b1, U);
    for (int i = 0; i < 3; i++) go(F0, F4, "t2_dwell", F0, F6, 1'b1, U);
    go(F0, F4, "t2_close",    F0, F6, 1'b0, U);
    go(F0, F4, "t2_resume",   F6, F6, 1'b0, U);
    go(F0, F6, "t2_arrive6",  F0, F0, 1'b1, U);
    for (int i = 0; i < 3; i++) go(F0, F6, "t2_dwell6", F0, F0, 1'b1, U);
    go(F0, F6, "t2_close6",   F0, F0, 1'b0, U);
    go(F0, F6, "t2_idle",     F0, F0, 1'b0, N);

    // Equal-distance tie goes up, then the sweep reverses at IDLE.
    go(6'b010001, F3, "t3_latch", F0, 6'b010001, 1'b0, N);
    go(F0, F3, "t3_tie",      F5, 6'b010001, 1'b0, U);
    go(F0, F5, "t3_arrive",   F0, F1, 1'b1, U);
    for (int i = 0; i < 3; i++) go(F0, F5, "t3_dwell", F0, F1, 1'b1, U);
    go(F0, F5, "t3_close",    F0, F1, 1'b0, U);
    go(F0, F5, "t3_reverse",  F1, F1, 1'b0, D);
    go(F0, F1, "t3_arrive1",  F0, F0, 1'b1, D);
    for (int i = 0; i < 3; i++) go(F0, F1, "t3_dwell1", F0, F0, 1'b1, D);
    go(F0, F1, "t3_close1",   F0, F0, 1'b0, D);
    go(F0, F1, "t3_idle",     F0, F0, 1'b0, N);

    // Call at the current floor while idle, then re-open on dwell cycle 3.
    go(F4, F4, "t4_latch",  F0, F4, 1'b0, N);
    go(F0, F4, "t4_open",   F0, F0, 1'b1, N);
    go(F0, F4, "t4_dwell2", F0, F0, 1'b1, N);
    go(F0, F4, "t4_dwell3", F0, F0, 1'b1, N);
    go(F4, F4, "t4_reopen", F0, F0, 1'b1, N);
    for (int i = 0; i < 3; i++) go(F0, F4, "t4_dwell_re", F0, F0, 1'b1, N);
    go(F0, F4, "t4_close",  F0, F0, 1'b0, N);

    // Reset during SERVE drops every request.
    go(6'b110000, F1, "t5_latch", F0, 6'b110000, 1'b0, N);
    go(F0, F1, "t5_target", F5, 6'b110000, 1'b0, U);
    reset = 1'b1;
    go(F0, F2, "t5_reset",  F0, F0, 1'b0, N);
    reset = 1'b0;
    go(F0, F2, "t5_quiet0", F0, F0, 1'b0, N);
    go(F0, F2, "t5_quiet1", F0, F0, 1'b0, N);

    // Invalid position holds IDLE; multi-hot position holds the SERVE target.
    go(F3, F0, "t6_latch",     F0, F3, 1'b0, N);
    go(F0, F0, "t6_hold0",     F0, F3, 1'b0, N);
    go(F0, F0, "t6_hold1",     F0, F3, 1'b0, N);
    go(F0, F1, "t6_valid",     F3, F3, 1'b0, U);
    go(F0, 6'b000011, "t6_multihot", F3, F3, 1'b0, U);
    go(F0, F3, "t6_arrive",    F0, F0, 1'b1, U);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/floor_scheduler.md
# floor_scheduler

Request scheduler for the elevator car. Latches floor-call button presses, picks the next target floor with a SCAN (sweep) policy, and drives `nextFloor` into the direction FSM. It also times the door-open dwell at each served floor and clears served requests. It sits between the button inputs and the direction/floor-tracking logic.

## Interface
- `FLOORS`, 6: number of floors; one bit per floor; bit 0 = floor 1 (6'b000001), bit FLOORS-1 = top (6'b100000).
- `DOOR_CYCLES`, 4: number of cycles `doorOpen` stays high per stop (≥1).

- `clk`  in  1  system clock, all state on posedge.
- `reset`  in  1  one clock; reset is synchronous and active-high.
- `callReq`  in  FLOORS  button presses, any number of bits, one-cycle pulses or held; OR'd into pending.
- `currentFloor`  in  FLOORS  one-hot car position; all-zero or multi-hot = invalid (between floors).
- `nextFloor`  out  FLOORS  registered one-hot target; 6'b000000 = no target.
- `pending`  out  FLOORS  registered outstanding requests.
- `doorOpen`  out  1  registered; high while the car dwells at a served floor.
- `sweep`  out  2  registered sweep direction: 2'b10 up, 2'b01 down, 2'b00 none.

## Operation
- Reset values: `pending`=0, `nextFloor`=0, `doorOpen`=0, `sweep`=2'b00, state IDLE, dwell counter 0. Reset mid-operation discards all requests and closes the door in the same cycle.
- `pending` update every cycle: `pending <= (pending | callReq) & ~clr`. `clr` = `currentFloor` on the cycle the FSM enters DOOR, and also throughout DOOR. Clear wins over a simultaneous `callReq` bit on that floor.
- Target selection, combinational from registered `pending` and `currentFloor`:
  - up = nearest pending bit strictly above the current floor; down = nearest pending bit strictly below.
  - sweep 2'b10: pick up if it exists, else down and flip to 2'b01. Mirror this for 2'b01.
  - sweep 2'b00: pick the nearer of up/down. A distance tie goes up.
- States:
  - IDLE:
    - If `currentFloor` is invalid, hold.
    - Else if `pending & currentFloor` ≠ 0, go to DOOR.
    - Else if `pending` ≠ 0, go to SERVE: load `nextFloor`=target and set `sweep` toward it.
    - Else set `sweep`=2'b00.
  - SERVE:
    - If `currentFloor == nextFloor`, go to DOOR: `nextFloor`←0, clear that bit.
    - Else, if `currentFloor` is valid, reload `nextFloor` with the target in the current sweep. A newer, closer request in the sweep direction retargets the car.
    - If `currentFloor` is invalid, hold `nextFloor`.
    - If `pending` becomes 0 (not reachable except via reset), return to IDLE with `nextFloor`=0.
  - DOOR:
    - `doorOpen`=1 and the counter loads DOOR_CYCLES-1 on entry.
    - The counter decrements each cycle. At 0 the FSM goes to IDLE and `doorOpen` falls.
    - A `callReq` bit matching `currentFloor` during DOOR is not latched and reloads the counter (door re-open).
    - Other `callReq` bits latch normally.
- `nextFloor` is always 0 or one-hot. It is never a floor absent from `pending`, except while SERVE holds a stale target under an invalid `currentFloor`.

## Timing
- `callReq` at cycle t is visible on `pending` at t+1. Earliest `nextFloor` is at t+2 (IDLE decision on registered `pending`).
- Arrival: `currentFloor == nextFloor` at cycle t makes `nextFloor`=0, `doorOpen`=1, and clears the `pending` bit at t+1.
- `doorOpen` is high for exactly DOOR_CYCLES consecutive cycles absent re-open. The next `nextFloor` is valid 1 cycle after `doorOpen` falls (IDLE → SERVE).
- Request at the current floor while idle: `doorOpen` rises 2 cycles after the `callReq` pulse, and `nextFloor` stays 0.
- Sweep reversal happens only at the IDLE → SERVE decision, never mid-SERVE.

## Test plan
- Reset, then `currentFloor`=6'b000001 and pulse `callReq`=6'b100000 → `nextFloor`=6'b100000 and `sweep`=2'b10 two cycles later. Then `currentFloor`=6'b100000 → next cycle `nextFloor`=0, `doorOpen`=1 for 4 cycles, `pending`=0, then `sweep`=2'b00.
- Car at 6'b000010 in SERVE toward 6'b100000, pulse `callReq`=6'b001000 → `nextFloor` becomes 6'b001000 one cycle after `pending` shows it. Serve it, then `nextFloor` returns to 6'b100000.
- Idle at 6'b000100 with `sweep`=2'b00, pulse `callReq`=6'b010001 (floors 1 and 5, distance 2 each) → tie goes up: `nextFloor`=6'b010000. After serving floor 5, `sweep` flips to 2'b01 and `nextFloor`=6'b000001.
- During DOOR at 6'b001000, pulse `callReq`=6'b001000 on dwell cycle 3 → `pending` bit stays 0 and `doorOpen` stays high 4 more cycles (7 total).
- Assert `reset` during SERVE with `pending`=6'b110000 → next cycle all outputs are 0 and no target is issued until a new `callReq`.
- `currentFloor`=6'b000000 in IDLE with `pending`=6'b000100 → no transition and `nextFloor` stays 0. Set `currentFloor`=6'b000001 → `nextFloor`=6'b000100 next cycle.
